// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage PC owner.
//  Holds the fetch PC, issues instruction-memory requests over a req/ack
//  handshake and loads the IF/ID register (ins_d, pc_d, valid_d). A word that
//  returns while D is stalled is parked in a one-entry buffer until D frees up.
//  Redirect targets from the D stage (j/jr/taken branch) are captured here.
// Ports:
//  clk, rst_n                  clock (rising edge), async active-low reset
//  stall_i                     hold IF/ID, PC and buffer
//  redirect_i, npc_i           control-flow change and its target
//  imem_req_o, imem_addr_o     fetch request / address (= pc_f_o)
//  imem_ack_i, imem_rdata_i    response strobe / instruction word
//  pc_f_o                      current fetch PC
//  ins_d_o, pc_d_o, valid_d_o  IF/ID register
// Configuration:
//  DELAY_SLOT_EN  defined   -> word in F at redirect time is delivered (delay slot)
//                 undefined -> redirect squashes the word in F
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] npc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_f_o,
  output logic [31:0] ins_d_o,
  output logic [31:0] pc_d_o,
  output logic        valid_d_o
);

  typedef enum logic {S_REQ, S_BUF} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ins_d_q, ins_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic        kill_q, kill_d;

  logic        take_redir;
  logic [31:0] tgt_in;
  logic [31:0] next_pc;

  // A redirect seen during a stall is dropped; the hazard unit re-asserts it.
  assign take_redir = redirect_i & ~stall_i;
  assign tgt_in     = {npc_i[31:2], 2'b00};
  assign next_pc    = redir_pend_q ? redir_tgt_q : pc_f_q + 32'd4;

  // Gated with rst_n so no request is visible while reset is held.
  assign imem_req_o  = rst_n & (state_q == S_REQ);
  assign imem_addr_o = pc_f_q;
  assign pc_f_o      = pc_f_q;
  assign ins_d_o     = ins_d_q;
  assign pc_d_o      = pc_d_q;
  assign valid_d_o   = valid_d_q;

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    ins_d_d      = ins_d_q;
    pc_d_d       = pc_d_q;
    valid_d_d    = valid_d_q;
    buf_ins_d    = buf_ins_q;
    buf_pc_d     = buf_pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    kill_d       = kill_q;
    case (state_q)
      S_REQ: begin
        if (imem_ack_i) begin
          if (kill_q) begin
            // Squashed fetch returns: drop it and head for the target. A fresh
            // redirect in the same cycle supersedes the pending one.
            kill_d       = 1'b0;
            redir_pend_d = 1'b0;
            pc_f_d       = take_redir ? tgt_in : redir_tgt_q;
            if (!stall_i) begin
              valid_d_d = 1'b0;
              ins_d_d   = NOP_WORD;
            end
          end else if (stall_i) begin
            buf_ins_d = imem_rdata_i;
            buf_pc_d  = pc_f_q;
            state_d   = S_BUF;
          end else begin
            redir_pend_d = 1'b0;
`ifdef DELAY_SLOT_EN
            ins_d_d   = imem_rdata_i;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
            pc_f_d    = take_redir ? tgt_in : next_pc;
`else
            if (take_redir) begin
              valid_d_d = 1'b0;
              ins_d_d   = NOP_WORD;
              pc_f_d    = tgt_in;
            end else begin
              ins_d_d   = imem_rdata_i;
              pc_d_d    = pc_f_q;
              valid_d_d = 1'b1;
              pc_f_d    = next_pc;
            end
`endif
          end
        end else begin
          if (!stall_i) begin
            valid_d_d = 1'b0;
            ins_d_d   = NOP_WORD;
          end
          // Request still in flight: remember the target for when it returns.
          if (take_redir) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = tgt_in;
`ifndef DELAY_SLOT_EN
            kill_d       = 1'b1;
`endif
          end
        end
      end
      S_BUF: begin
        if (!stall_i) begin
          state_d      = S_REQ;
          redir_pend_d = 1'b0;
`ifdef DELAY_SLOT_EN
          ins_d_d   = buf_ins_q;
          pc_d_d    = buf_pc_q;
          valid_d_d = 1'b1;
          pc_f_d    = take_redir ? tgt_in : next_pc;
`else
          if (take_redir) begin
            valid_d_d = 1'b0;
            ins_d_d   = NOP_WORD;
            pc_f_d    = tgt_in;
          end else begin
            ins_d_d   = buf_ins_q;
            pc_d_d    = buf_pc_q;
            valid_d_d = 1'b1;
            pc_f_d    = next_pc;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_f_q       <= RESET_PC;
      ins_d_q      <= NOP_WORD;
      pc_d_q       <= 32'd0;
      valid_d_q    <= 1'b0;
      buf_ins_q    <= 32'd0;
      buf_pc_q     <= 32'd0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'd0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      ins_d_q      <= ins_d_d;
      pc_d_q       <= pc_d_d;
      valid_d_q    <= valid_d_d;
      buf_ins_q    <= buf_ins_d;
      buf_pc_q     <= buf_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      kill_q       <= kill_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle vector table (inputs plus the
// expected request/address before the edge and IF/ID contents after it),
// followed by hand-written reset sequences. Memory words are a fixed function
// of the address so delivered instructions can be tied back to their PC.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, redirect_i, imem_ack_i;
  logic [31:0] npc_i, imem_rdata_i;
  logic        imem_req_o, valid_d_o;
  logic [31:0] imem_addr_o, pc_f_o, ins_d_o, pc_d_o;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata_i = word_of(imem_addr_o);

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .npc_i        (npc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_f_o       (pc_f_o),
    .ins_d_o      (ins_d_o),
    .pc_d_o       (pc_d_o),
    .valid_d_o    (valid_d_o)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] npc;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcd;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] n,
                              input logic a, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.npc = n; v.ack = a;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pcd = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // IF/ID check after an edge: real instruction must carry word_of(pc_d).
  task automatic chk_ifid(input string tag, input logic ev, input logic [31:0] ep);
    chk({tag, " valid_d"}, {31'd0, valid_d_o}, {31'd0, ev});
    if (ev) begin
      chk({tag, " pc_d"}, pc_d_o, ep);
      chk({tag, " ins_d"}, ins_d_o, word_of(ep));
    end else begin
      chk({tag, " ins_d bubble"}, ins_d_o, 32'h0);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] n, input logic a);
    stall_i = s; redirect_i = r; npc_i = n; imem_ack_i = a;
  endtask

  initial begin
    // stall, redir, npc, ack | req, addr (before edge) | valid, pc_d (after edge)
    vt[0]  = mk(0, 0, 32'h0,         1, 1, 32'h0000_3000, 1, 32'h0000_3000);
    vt[1]  = mk(1, 0, 32'h0,         1, 1, 32'h0000_3004, 1, 32'h0000_3000);
    vt[2]  = mk(1, 0, 32'h0,         0, 0, 32'h0000_3004, 1, 32'h0000_3000);
    vt[3]  = mk(1, 0, 32'h0,         0, 0, 32'h0000_3004, 1, 32'h0000_3000);
    vt[4]  = mk(0, 0, 32'h0,         0, 0, 32'h0000_3004, 1, 32'h0000_3004);
    vt[5]  = mk(0, 1, 32'h0000_3100, 0, 1, 32'h0000_3008, 0, 32'h0);
    vt[6]  = mk(0, 0, 32'h0,         0, 1, 32'h0000_3008, 0, 32'h0);
    vt[7]  = mk(0, 0, 32'h0,         1, 1, 32'h0000_3008, 0, 32'h0);
    vt[8]  = mk(0, 0, 32'h0,         1, 1, 32'h0000_3100, 1, 32'h0000_3100);
    vt[9]  = mk(1, 1, 32'h0000_5000, 1, 1, 32'h0000_3104, 1, 32'h0000_3100);
    vt[10] = mk(0, 0, 32'h0,         0, 0, 32'h0000_3104, 1, 32'h0000_3104);
    vt[11] = mk(0, 0, 32'h0,         1, 1, 32'h0000_3108, 1, 32'h0000_3108);
    vt[12] = mk(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0000_310C, 0, 32'h0);
    vt[13] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
    vt[14] = mk(0, 0, 32'h0,         1, 1, 32'h0000_0000, 1, 32'h0000_0000);
    vt[15] = mk(0, 1, 32'h0000_2003, 0, 1, 32'h0000_0004, 0, 32'h0);
    vt[16] = mk(0, 0, 32'h0,         1, 1, 32'h0000_0004, 0, 32'h0);
    vt[17] = mk(0, 0, 32'h0,         1, 1, 32'h0000_2000, 1, 32'h0000_2000);
    vt[18] = mk(0, 0, 32'h0,         0, 1, 32'h0000_2004, 0, 32'h0);
    vt[19] = mk(0, 0, 32'h0,         1, 1, 32'h0000_2004, 1, 32'h0000_2004);
    vt[20] = mk(1, 0, 32'h0,         1, 1, 32'h0000_2008, 1, 32'h0000_2004);
    vt[21] = mk(0, 1, 32'h0000_3200, 0, 0, 32'h0000_2008, 0, 32'h0);
    vt[22] = mk(0, 0, 32'h0,         1, 1, 32'h0000_3200, 1, 32'h0000_3200);
`ifdef DELAY_SLOT_EN
    // Word in F at redirect time is the delay slot and is delivered.
    vt[7].exp_valid  = 1; vt[7].exp_pcd  = 32'h0000_3008;
    vt[12].exp_valid = 1; vt[12].exp_pcd = 32'h0000_310C;
    vt[16].exp_valid = 1; vt[16].exp_pcd = 32'h0000_0004;
    vt[21].exp_valid = 1; vt[21].exp_pcd = 32'h0000_2008;
`endif

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0);
    @(posedge clk); #1;
    chk("rst req", {31'd0, imem_req_o}, 32'd0);
    chk("rst addr", imem_addr_o, 32'h0000_3000);
    chk("rst pc_f", pc_f_o, 32'h0000_3000);
    chk("rst ins_d", ins_d_o, 32'h0);
    chk("rst pc_d", pc_d_o, 32'h0);
    chk("rst valid_d", {31'd0, valid_d_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vt[i].stall, vt[i].redir, vt[i].npc, vt[i].ack);
      #1;
      chk($sformatf("v%0d req", i), {31'd0, imem_req_o}, {31'd0, vt[i].exp_req});
      chk($sformatf("v%0d addr", i), imem_addr_o, vt[i].exp_addr);
      chk($sformatf("v%0d pc_f", i), pc_f_o, vt[i].exp_addr);
      @(posedge clk); #1;
      chk_ifid($sformatf("v%0d", i), vt[i].exp_valid, vt[i].exp_pcd);
    end

    // Reset asserted mid-request: outputs return to reset values at once.
    @(negedge clk);
    drive(0, 0, 32'h0, 0);
    #1;
    chk("midrst pre req", {31'd0, imem_req_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst req", {31'd0, imem_req_o}, 32'd0);
    chk("midrst addr", imem_addr_o, 32'h0000_3000);
    chk("midrst ins_d", ins_d_o, 32'h0);
    chk("midrst pc_d", pc_d_o, 32'h0);
    chk("midrst valid_d", {31'd0, valid_d_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart at RESET_PC, one instruction per cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 1);
      #1;
      chk($sformatf("restart%0d addr", k), imem_addr_o, 32'h0000_3000 + 32'(4 * k));
      @(posedge clk); #1;
      chk_ifid($sformatf("restart%0d", k), 1'b1, 32'h0000_3000 + 32'(4 * k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
